// File: rtl/coherence_bus_arbiter_if.sv
// coherence_bus_arbiter_if: per-CPU cache request/response and RAM port bundle
// slave  : arbiter side (takes cache requests and RAM status, drives waits, loads, RAM strobes, snoops)
// master : cache/RAM side (drives requests and RAM status, observes the arbiter outputs)
interface coherence_bus_arbiter_if #(parameter int CPUS = 2);
    logic [CPUS-1:0]       iren, dren, dwen, ccwrite, cctrans;
    logic [CPUS-1:0]       iwait, dwait, ccwait, ccinv;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
    logic [31:0]           ramload, ramaddr, ramstore;
    logic [1:0]            ramstate;
    logic                  ramren, ramwen;
    modport slave (
        input  iren, dren, dwen, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr, ramaddr, ramstore, ramren, ramwen
    );
    modport master (
        output iren, dren, dwen, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr, ramaddr, ramstore, ramren, ramwen
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: arbitrates 2 CPUs' icache/dcache requests onto one RAM port with MSI snooping
// clk, rst : clock, asynchronous active-high reset
// bus      : slave modport carrying cache requests/responses, snoop controls and the RAM port
module coherence_bus_arbiter #(
    parameter int CPUS = 2
) (
    input logic clk,
    input logic rst,
    coherence_bus_arbiter_if.slave bus
);
    localparam logic [1:0] ACCESS = 2'd2;
    typedef enum logic [2:0] {IDLE, SNOOP, FWD, DLOAD, DSTORE, ILOAD} state_t;
    state_t state, nxt;
    logic req, rr_d, rr_i, gnt, done_d, done_i, acc, r, o;
    logic [1:0] dreq, iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic ramren, ramwen;
    logic [31:0] ramaddr, ramstore;

    if (CPUS != 2) begin : g_cpus
        $error("coherence_bus_arbiter supports only CPUS=2");
    end

    assign r = req;
    assign o = ~req;
    assign acc = bus.ramstate == ACCESS;
    // a dcache needs service for reads, writebacks and pending state transitions
    assign dreq = bus.dren | bus.dwen | bus.cctrans;
    assign gnt = |dreq ? (dreq[rr_d] ? rr_d : ~rr_d) : (bus.iren[rr_i] ? rr_i : ~rr_i);

    always_comb begin
        nxt = state;
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        ccwait = '0;
        ccinv = '0;
        ccsnoopaddr = '0;
        ramren = 1'b0;
        ramwen = 1'b0;
        ramaddr = '0;
        ramstore = '0;
        done_d = 1'b0;
        done_i = 1'b0;
        case (state)
            IDLE: nxt = (bus.dwen[gnt] & ~bus.cctrans[gnt]) ? DSTORE :
                        (bus.dren[gnt] | bus.cctrans[gnt]) ? SNOOP :
                        bus.iren[gnt] ? ILOAD : IDLE;
            SNOOP: begin
                ccwait[o] = 1'b1;
                ccsnoopaddr[o] = bus.daddr[r];
                ccinv[o] = bus.ccwrite[r];
                if (!(bus.dren[r] | bus.cctrans[r])) nxt = IDLE;
                else if (bus.ccwrite[o] & bus.dwen[o]) nxt = FWD;
                else if (bus.dren[r]) nxt = DLOAD;
                else begin
                    // S->M upgrade: invalidation alone completes it
                    dwait[r] = 1'b0;
                    done_d = 1'b1;
                    nxt = IDLE;
                end
            end
            FWD: begin
                // owner's dirty line is written back and handed to the requester in one RAM write
                ramwen = 1'b1;
                ramaddr = bus.daddr[o];
                ramstore = bus.dstore[o];
                dload[r] = bus.dstore[o];
                ccwait[o] = 1'b1;
                if (!(bus.dren[r] | bus.cctrans[r])) nxt = IDLE;
                else if (acc) begin
                    dwait = '0;
                    done_d = 1'b1;
                    nxt = IDLE;
                end
            end
            DLOAD: begin
                ramren = 1'b1;
                ramaddr = bus.daddr[r];
                if (!bus.dren[r]) nxt = IDLE;
                else if (acc) begin
                    dload[r] = bus.ramload;
                    dwait[r] = 1'b0;
                    done_d = 1'b1;
                    nxt = IDLE;
                end
            end
            DSTORE: begin
                ramwen = 1'b1;
                ramaddr = bus.daddr[r];
                ramstore = bus.dstore[r];
                if (!bus.dwen[r]) nxt = IDLE;
                else if (acc) begin
                    dwait[r] = 1'b0;
                    done_d = 1'b1;
                    nxt = IDLE;
                end
            end
            ILOAD: begin
                ramren = 1'b1;
                ramaddr = bus.iaddr[r];
                if (!bus.iren[r]) nxt = IDLE;
                else if (acc) begin
                    iload[r] = bus.ramload;
                    iwait[r] = 1'b0;
                    done_i = 1'b1;
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req <= 1'b0;
            rr_d <= 1'b0;
            rr_i <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE) req <= gnt;
            if (done_d) rr_d <= ~req;
            if (done_i) rr_i <= ~req;
        end
    end

    assign bus.iwait = iwait;
    assign bus.dwait = dwait;
    assign bus.iload = iload;
    assign bus.dload = dload;
    assign bus.ccwait = ccwait;
    assign bus.ccinv = ccinv;
    assign bus.ccsnoopaddr = ccsnoopaddr;
    assign bus.ramren = ramren;
    assign bus.ramwen = ramwen;
    assign bus.ramaddr = ramaddr;
    assign bus.ramstore = ramstore;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb_coherence_bus_arbiter: scoreboard bench for coherence_bus_arbiter with a latency-programmable RAM model
module tb_coherence_bus_arbiter;
    typedef struct {
        logic [1:0]  iw, dw, ccw, cci, rs;
        logic        ren, wen;
        logic [31:0] il0, il1, dl0, dl1, addr, store, sa0, sa1;
    } exp_t;

    logic clk, rst, err;
    int checks = 0, errors = 0, cnt = 0, lat = 0;
    logic [1:0] dn_i = '0, dn_d = '0;
    exp_t sb[$];
    exp_t m, e;

    coherence_bus_arbiter_if #(.CPUS(2)) bus ();
    coherence_bus_arbiter #(.CPUS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ramload = 32'hA000_0000 | bus.ramaddr;
    always_comb bus.ramstate = (bus.ramren | bus.ramwen) ? ((cnt >= lat) ? 2'd2 : (err ? 2'd3 : 2'd1)) : 2'd0;
    always @(posedge clk) cnt <= (rst || !(bus.ramren | bus.ramwen)) ? 0 : cnt + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endfunction

    function automatic exp_t base();
        exp_t x;
        x.iw = 2'b11; x.dw = 2'b11; x.ccw = '0; x.cci = '0; x.rs = 2'd2;
        x.ren = 1'b0; x.wen = 1'b0;
        x.il0 = '0; x.il1 = '0; x.dl0 = '0; x.dl1 = '0; x.addr = '0; x.store = '0; x.sa0 = '0; x.sa1 = '0;
        return x;
    endfunction

    always @(negedge clk) begin
        dn_i = rst ? 2'b00 : ~bus.iwait;
        dn_d = rst ? 2'b00 : ~bus.dwait;
        if (!rst) begin
            chk("strobe_exclusive", 32'(bus.ramren & bus.ramwen), 32'd0);
            if ((bus.ramren | bus.ramwen) && bus.ramstate != 2'd2)
                chk("wait_before_access", 32'({bus.iwait, bus.dwait}), 32'hF);
            if (!(&bus.iwait) || !(&bus.dwait)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: iwait=%b dwait=%b, required no completion", bus.iwait, bus.dwait);
                end else begin
                    m = sb.pop_front();
                    chk("iwait", 32'(bus.iwait), 32'(m.iw));
                    chk("dwait", 32'(bus.dwait), 32'(m.dw));
                    chk("iload0", bus.iload[0], m.il0);
                    chk("iload1", bus.iload[1], m.il1);
                    chk("dload0", bus.dload[0], m.dl0);
                    chk("dload1", bus.dload[1], m.dl1);
                    chk("ramren", 32'(bus.ramren), 32'(m.ren));
                    chk("ramwen", 32'(bus.ramwen), 32'(m.wen));
                    chk("ramaddr", bus.ramaddr, m.addr);
                    chk("ramstore", bus.ramstore, m.store);
                    chk("ramstate", 32'(bus.ramstate), 32'(m.rs));
                    chk("ccwait", 32'(bus.ccwait), 32'(m.ccw));
                    chk("ccinv", 32'(bus.ccinv), 32'(m.cci));
                    chk("ccsnoopaddr0", bus.ccsnoopaddr[0], m.sa0);
                    chk("ccsnoopaddr1", bus.ccsnoopaddr[1], m.sa1);
                end
            end
        end
    end

    // a cache drops its request the cycle after it sees its wait go low
    task automatic clr();
        for (int c = 0; c < 2; c++) begin
            if (dn_d[c]) begin
                bus.dren[c] = 1'b0; bus.dwen[c] = 1'b0; bus.cctrans[c] = 1'b0; bus.ccwrite[c] = 1'b0;
            end
            if (dn_i[c]) bus.iren[c] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            clr();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; err = 1'b0;
        bus.iren = '0; bus.dren = '0; bus.dwen = '0; bus.ccwrite = '0; bus.cctrans = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_iwait", 32'(bus.iwait), 32'h3);
        chk("rst_dwait", 32'(bus.dwait), 32'h3);
        chk("rst_ccwait", 32'(bus.ccwait), 32'h0);
        chk("rst_ccinv", 32'(bus.ccinv), 32'h0);
        chk("rst_ramren", 32'(bus.ramren), 32'h0);
        chk("rst_ramwen", 32'(bus.ramwen), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_dload0", bus.dload[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // icache read, two BUSY cycles before ACCESS
        lat = 2;
        bus.iren[0] = 1'b1; bus.iaddr[0] = 32'h40;
        e = base(); e.iw = 2'b10; e.il0 = 32'hA000_0040; e.ren = 1'b1; e.addr = 32'h40; sb.push_back(e);
        drain();

        // contention: CPU0 d, then CPU1 d, then CPU0 i
        lat = 1;
        bus.dren = 2'b11; bus.iren[0] = 1'b1;
        bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h200; bus.iaddr[0] = 32'h44;
        e = base(); e.dw = 2'b10; e.dl0 = 32'hA000_0100; e.ren = 1'b1; e.addr = 32'h100; sb.push_back(e);
        e = base(); e.dw = 2'b01; e.dl1 = 32'hA000_0200; e.ren = 1'b1; e.addr = 32'h200; sb.push_back(e);
        e = base(); e.iw = 2'b10; e.il0 = 32'hA000_0044; e.ren = 1'b1; e.addr = 32'h44; sb.push_back(e);
        drain();

        // forward: CPU1 holds 0x80 in M, CPU0 read-miss on it
        bus.dren[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h80;
        bus.ccwrite[1] = 1'b1; bus.dwen[1] = 1'b1; bus.daddr[1] = 32'h80; bus.dstore[1] = 32'hBEEF;
        e = base(); e.dw = 2'b00; e.dl0 = 32'hBEEF; e.wen = 1'b1; e.addr = 32'h80; e.store = 32'hBEEF;
        e.ccw = 2'b10; sb.push_back(e);
        drain();

        // round robin: CPU0 was served last, so CPU1 wins this tie
        lat = 0;
        bus.dren = 2'b11; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
        e = base(); e.dw = 2'b01; e.dl1 = 32'hA000_0020; e.ren = 1'b1; e.addr = 32'h20; sb.push_back(e);
        e = base(); e.dw = 2'b10; e.dl0 = 32'hA000_0010; e.ren = 1'b1; e.addr = 32'h10; sb.push_back(e);
        drain();

        // upgrade S->M: invalidate CPU1, no RAM access
        bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1; bus.daddr[0] = 32'h60;
        e = base(); e.dw = 2'b10; e.ccw = 2'b10; e.cci = 2'b10; e.sa1 = 32'h60; e.rs = 2'd0; sb.push_back(e);
        drain();

        // writeback through ERROR cycles
        lat = 2; err = 1'b1;
        bus.dwen[1] = 1'b1; bus.daddr[1] = 32'hC0; bus.dstore[1] = 32'h1234;
        e = base(); e.dw = 2'b01; e.wen = 1'b1; e.addr = 32'hC0; e.store = 32'h1234; sb.push_back(e);
        drain();
        err = 1'b0;

        // reset in the middle of a DLOAD
        lat = 5;
        bus.dren[0] = 1'b1; bus.daddr[0] = 32'h500;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_dload_ramren", 32'(bus.ramren), 32'h1);
        rst = 1'b1; bus.dren = '0;
        @(negedge clk);
        chk("rst_mid_iwait", 32'(bus.iwait), 32'h3);
        chk("rst_mid_dwait", 32'(bus.dwait), 32'h3);
        chk("rst_mid_ramren", 32'(bus.ramren), 32'h0);
        chk("rst_mid_ccwait", 32'(bus.ccwait), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
